// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS controller:
// FSM states, opcode/funct values, instruction classes and ALU operand/op codes.
package mc_ctrl_pkg;

    // Nine states need four bits.
    typedef enum logic [3:0] {
        ST_INIT,
        ST_IF,
        ST_IW,
        ST_ID,
        ST_EX,
        ST_LD,
        ST_ST,
        ST_RDW,
        ST_WB
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] FN_SLL     = 6'b000000;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ADDIU,
        CLS_LW,
        CLS_SW,
        CLS_BNE,
        CLS_SLL
    } inst_class_t;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_SLL = 3'b010;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: opcode/funct -> instruction class and a known flag.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] i_opcode,
    input  logic [OPC_W-1:0] i_funct,
    output inst_class_t      o_class,
    output logic             o_known
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_class; no latch is inferred.
        o_class = CLS_NONE;
        case (i_opcode)
            OP_ADDIU:   o_class = CLS_ADDIU;
            OP_LW:      o_class = CLS_LW;
            OP_SW:      o_class = CLS_SW;
            OP_BNE:     o_class = CLS_BNE;
            OP_SPECIAL: if (i_funct == FN_SLL) o_class = CLS_SLL;
            default:    o_class = CLS_NONE;
        endcase
    end

    assign o_known = (o_class != CLS_NONE);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM sequencing fetch, decode, execute, memory and write-back.
// Defining MC_PERF_CNT_EN adds the cycle_cnt / inst_cnt performance counters.
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    input  logic             zero,
    input  logic             Inst_Req_Ready,
    input  logic             Inst_Valid,
    input  logic             Mem_Req_Ready,
    input  logic             Read_data_Valid,
    output logic             Inst_Req_Valid,
    output logic             Inst_Ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Read_data_Ready,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
`endif
);

    state_t      r_state;
    state_t      w_state_nxt;
    inst_class_t w_class;
    logic        w_known;
    logic        w_ex_src_a;
    logic [1:0]  w_ex_src_b;
    logic [2:0]  w_ex_alu_op;

    logic        r_inst_req_valid;
    logic        r_inst_ready;
    logic        r_pc_write;
    logic        r_bne_ex;
    logic        r_alu_src_a;
    logic [1:0]  r_alu_src_b;
    logic [2:0]  r_alu_op;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_rd_ready;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_reg_dst;
    logic        r_illegal;

    mc_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_class  (w_class),
        .o_known  (w_known)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: w_state_nxt = ST_IF;
            ST_IF:   if (Inst_Req_Ready) w_state_nxt = ST_IW;
            ST_IW:   if (Inst_Valid) w_state_nxt = ST_ID;
            ST_ID:   w_state_nxt = w_known ? ST_EX : ST_IF;
            ST_EX: begin
                case (w_class)
                    CLS_LW:  w_state_nxt = ST_LD;
                    CLS_SW:  w_state_nxt = ST_ST;
                    CLS_BNE: w_state_nxt = ST_IF;
                    default: w_state_nxt = ST_WB;
                endcase
            end
            ST_LD:   if (Mem_Req_Ready) w_state_nxt = ST_RDW;
            ST_RDW:  if (Read_data_Valid) w_state_nxt = ST_WB;
            ST_ST:   if (Mem_Req_Ready) w_state_nxt = ST_IF;
            ST_WB:   w_state_nxt = ST_IF;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Execute-stage ALU operands: address/immediate add unless compare or shift.
    always_comb begin
        w_ex_src_a  = 1'b1;
        w_ex_src_b  = SRCB_IMM;
        w_ex_alu_op = ALUOP_ADD;
        case (w_class)
            CLS_BNE: begin
                w_ex_src_b  = SRCB_RT;
                w_ex_alu_op = ALUOP_SUB;
            end
            CLS_SLL: begin
                w_ex_src_b  = SRCB_RT;
                w_ex_alu_op = ALUOP_SLL;
            end
            default: ;
        endcase
    end

    // NOTE: outputs are registered from the next state with non-blocking assignments,
    // so the async reset clears every enable immediately and none can pulse after rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_INIT;
            r_inst_req_valid <= 1'b0;
            r_inst_ready     <= 1'b0;
            r_pc_write       <= 1'b0;
            r_bne_ex         <= 1'b0;
            r_alu_src_a      <= 1'b0;
            r_alu_src_b      <= SRCB_RT;
            r_alu_op         <= ALUOP_ADD;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_rd_ready       <= 1'b0;
            r_reg_write      <= 1'b0;
            r_mem_to_reg     <= 1'b0;
            r_reg_dst        <= 1'b0;
            r_illegal        <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_inst_req_valid <= (w_state_nxt == ST_IF);
            r_inst_ready     <= (w_state_nxt == ST_IW);
            r_pc_write       <= (w_state_nxt == ST_ID);
            r_bne_ex         <= (w_state_nxt == ST_EX) && (w_class == CLS_BNE);
            r_mem_read       <= (w_state_nxt == ST_LD);
            r_mem_write      <= (w_state_nxt == ST_ST);
            r_rd_ready       <= (w_state_nxt == ST_RDW);
            r_reg_write      <= (w_state_nxt == ST_WB);
            r_reg_dst        <= (w_state_nxt == ST_WB) && (w_class == CLS_SLL);
            r_mem_to_reg     <= (w_state_nxt == ST_WB) && (w_class == CLS_LW);

            r_alu_src_a <= 1'b0;
            r_alu_src_b <= SRCB_RT;
            r_alu_op    <= ALUOP_ADD;
            if (w_state_nxt == ST_ID) begin
                r_alu_src_b <= SRCB_FOUR;
            end else if (w_state_nxt == ST_EX) begin
                r_alu_src_a <= w_ex_src_a;
                r_alu_src_b <= w_ex_src_b;
                r_alu_op    <= w_ex_alu_op;
            end

            if ((r_state == ST_ID) && !w_known) r_illegal <= 1'b1;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_inst_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
        end else begin
            if (r_state != ST_INIT) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if ((w_state_nxt == ST_ID) && (r_state != ST_ID)) r_inst_cnt <= r_inst_cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign inst_cnt  = r_inst_cnt;
`endif

    assign Inst_Req_Valid  = r_inst_req_valid;
    assign Inst_Ready      = r_inst_ready;
    assign IRWrite         = r_inst_ready & Inst_Valid;
    assign PCWrite         = r_pc_write | (r_bne_ex & ~zero);
    assign PCSource        = r_bne_ex;
    assign ALUSrcA         = r_alu_src_a;
    assign ALUSrcB         = r_alu_src_b;
    assign ALUOp           = r_alu_op;
    assign MemRead         = r_mem_read;
    assign MemWrite        = r_mem_write;
    assign Read_data_Ready = r_rd_ready;
    assign RegWrite        = r_reg_write;
    assign MemtoReg        = r_mem_to_reg;
    assign RegDst          = r_reg_dst;
    assign illegal         = r_illegal;

endmodule
